motion_ctrl: RTL

Controller that sequences on-screen object motion for the VGA display path. It merges direction requests from the board buttons and the PS/2 keyboard decoder under a fixed-priority arbitration, and runs a start/pause/reset state machine from keyboard command keys. Once per frame it updates a clamped object position. The registered `obj_x`/`obj_y` feed `pixel_gen`, which draws the object at that position.

---
 rtl/display_pkg.sv | 29 ++
 rtl/rise_detect.sv | 21 ++
 rtl/motion_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display path: run states, screen size,
// hold-counter geometry and the axis clamp used by the motion controller.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } run_state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int HOLD_W      = 5;
    localparam int HOLD_THRESH = 16;

    // Clamp a signed candidate coordinate into [0, hi]; no wrap-around.
    function automatic logic [9:0] clamp_axis(input logic signed [11:0] v,
                                              input int hi);
        logic signed [11:0] hi_s;
        hi_s = $signed(12'(hi));
        if (v[11])
            return '0;
        else if (v > hi_s)
            return 10'(hi);
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for one keyboard command level: one history flop and a
// single-cycle pulse. History clears in reset so a held key fires once after it.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge clk) begin
        if (!reset)
            hist_q <= 1'b0;
        else
            hist_q <= level_i;
    end

    assign pulse_o = level_i & ~hist_q;

endmodule

// File: rtl/motion_ctrl.sv
// Object motion sequencer: start/pause/reset FSM from keyboard command keys,
// button-over-keyboard direction arbitration and a clamped per-frame position.
module motion_ctrl #(
    parameter int SCREEN_W = display_pkg::SCREEN_W,
    parameter int SCREEN_H = display_pkg::SCREEN_H,
    parameter int OBJ_SIZE = 16,
    parameter int STEP     = 2,
    parameter int START_X  = 312,
    parameter int START_Y  = 232
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_s,
    input  logic       key_p,
    input  logic       key_r,
    input  logic       key_esc,
    output logic [9:0] obj_x,
    output logic [9:0] obj_y,
    output logic [1:0] run_state,
    output logic       moving
);

    import display_pkg::*;

    logic rise_s, rise_p, rise_r, rise_esc;
    logic cmd_s, cmd_p, cmd_r, cmd_esc;

    rise_detect u_rise_s   (.clk(clk), .reset(reset), .level_i(key_s),   .pulse_o(rise_s));
    rise_detect u_rise_p   (.clk(clk), .reset(reset), .level_i(key_p),   .pulse_o(rise_p));
    rise_detect u_rise_r   (.clk(clk), .reset(reset), .level_i(key_r),   .pulse_o(rise_r));
    rise_detect u_rise_esc (.clk(clk), .reset(reset), .level_i(key_esc), .pulse_o(rise_esc));

    // Only the highest-priority command of a cycle acts: ESC > R > P > S.
    assign cmd_esc = rise_esc;
    assign cmd_r   = rise_r & ~rise_esc;
    assign cmd_p   = rise_p & ~rise_r & ~rise_esc;
    assign cmd_s   = rise_s & ~rise_p & ~rise_r & ~rise_esc;

    run_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cmd_esc) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cmd_s)         state_d = RUN;
                RUN:     if (cmd_p)         state_d = PAUSE;
                PAUSE:   if (cmd_p | cmd_s) state_d = RUN;
                default:                    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        run_state = state_q;
    end

    logic       use_btn;
    logic       dir_u, dir_d, dir_l, dir_r, any_dir;
    logic       home, do_move;
    logic [11:0] step_w;
    logic signed [11:0] sum_x, sum_y;
    logic [9:0] new_x, new_y;

    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              moving_q, moving_d;

    // Any pressed button masks the whole keyboard direction set for the frame.
    assign use_btn = btn_up | btn_down | btn_left | btn_right;
    assign dir_u   = use_btn ? btn_up    : key_up;
    assign dir_d   = use_btn ? btn_down  : key_down;
    assign dir_l   = use_btn ? btn_left  : key_left;
    assign dir_r   = use_btn ? btn_right : key_right;
    assign any_dir = (dir_r ^ dir_l) | (dir_d ^ dir_u);

    // Commands resolve before motion, so a tick moves only if RUN survives them.
    assign home    = cmd_esc | cmd_r;
    assign do_move = frame_tick & (state_q == RUN) & (state_d == RUN) & ~home;

    assign step_w = (hold_q >= HOLD_W'(HOLD_THRESH)) ? 12'(2 * STEP) : 12'(STEP);
    assign sum_x  = $signed({2'b00, x_q}) + (dir_r ? $signed(step_w) : 12'sd0)
                                          - (dir_l ? $signed(step_w) : 12'sd0);
    assign sum_y  = $signed({2'b00, y_q}) + (dir_d ? $signed(step_w) : 12'sd0)
                                          - (dir_u ? $signed(step_w) : 12'sd0);
    assign new_x  = clamp_axis(sum_x, SCREEN_W - OBJ_SIZE);
    assign new_y  = clamp_axis(sum_y, SCREEN_H - OBJ_SIZE);

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        hold_d   = hold_q;
        moving_d = moving_q;
        if (home) begin
            x_d = 10'(START_X);
            y_d = 10'(START_Y);
            if (frame_tick)
                moving_d = 1'b0;
        end else if (do_move) begin
            x_d      = new_x;
            y_d      = new_y;
            moving_d = (new_x != x_q) || (new_y != y_q);
            if (!any_dir)
                hold_d = '0;
            else if (hold_q != '1)
                hold_d = hold_q + HOLD_W'(1);
        end else if (frame_tick) begin
            moving_d = 1'b0;
        end
        if ((state_q == RUN) && (state_d != RUN))
            hold_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            hold_q   <= '0;
            moving_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            hold_q   <= hold_d;
            moving_q <= moving_d;
        end
    end

    assign obj_x  = x_q;
    assign obj_y  = y_q;
    assign moving = moving_q;

endmodule
